sy_axi_rd_adapter: RTL and testbench

- Read-only AXI4 master that converts one cache/fetch read request into one AR burst and assembles the R beats into a line buffer.
- Sits between the cache refill logic (upstream) and the AXI crossbar master port (downstream).
- Drives the `sy_axi::req_t` and `sy_axi::resp_t` bundles.
- Write channels are tied off.

---
 rtl/sy_axi_rd_adapter_if.sv | 28 ++
 rtl/sy_axi_rd_adapter.sv | 227 ++++++++++++++++++++++
 tb/tb_sy_axi_rd_adapter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sy_axi_rd_adapter_if.sv
// Upstream request/response port of the AXI read adapter: the cache refill
// logic drives it through the master modport; the adapter uses the slave modport.
interface sy_axi_rd_adapter_if #(
  parameter int LINE_WORDS = 4
) ();

  logic                       req_valid_i;
  logic                       req_ready_o;
  logic                       req_type_i;
  logic [63:0]                req_addr_i;
  logic [2:0]                 req_size_i;
  logic [3:0]                 req_id_i;
  logic                       rsp_valid_o;
  logic                       rsp_ready_i;
  logic [64*LINE_WORDS-1:0]   rsp_data_o;
  logic                       rsp_err_o;

  modport master (
    output req_valid_i, req_type_i, req_addr_i, req_size_i, req_id_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_type_i, req_addr_i, req_size_i, req_id_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

endinterface

// File: rtl/sy_axi_rd_adapter.sv
// AXI4 read-only master: one refill request becomes one AR burst, R beats fill a line buffer.
// Optional watchdog enabled with `define SY_AXI_RD_TIMEOUT_EN.
package sy_axi;

  typedef enum logic {
    SINGLE_REQ     = 1'b0,
    CACHE_LINE_REQ = 1'b1
  } ad_req_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [1:0]  resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     ar_ready;
    logic     r_valid;
    r_chan_t  r;
  } resp_t;

endpackage

module sy_axi_rd_adapter
  import sy_axi::*;
#(
  parameter int LINE_WORDS     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sy_axi_rd_adapter_if.slave   bus,
  output req_t                 axi_req_o,
  input  resp_t                axi_resp_i
);

  localparam int CNT_W = $clog2(LINE_WORDS) + 1;
  localparam logic [63:0] LINE_MASK = 64'(LINE_WORDS * 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_RDATA,
    S_RESP
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  ad_req_t                       r_type;
  logic [63:0]                   r_addr;
  logic [2:0]                    r_size;
  logic [3:0]                    r_id;
  logic [LINE_WORDS-1:0][63:0]   r_buf;
  logic [CNT_W-1:0]              r_beat_cnt;
  logic                          r_err;

  logic              w_accept;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_rsp_hs;
  logic              w_timeout;
  logic [63:0]       w_ar_addr;
  logic [7:0]        w_ar_len;
  logic [2:0]        w_ar_size;
  logic [CNT_W-2:0]  w_beat_idx;
  logic              w_len_mismatch;
  logic              w_beat_err;
  logic              w_unused;

  assign w_accept = (r_state == S_IDLE)  && bus.req_valid_i;
  assign w_ar_hs  = (r_state == S_AR)    && axi_resp_i.ar_ready;
  assign w_r_hs   = (r_state == S_RDATA) && axi_resp_i.r_valid;
  assign w_rsp_hs = (r_state == S_RESP)  && bus.rsp_ready_i;

  // Line requests are aligned down to the line and always use full 64-bit beats.
  assign w_ar_addr = (r_type == CACHE_LINE_REQ) ? (r_addr & ~LINE_MASK) : r_addr;
  assign w_ar_len  = (r_type == CACHE_LINE_REQ) ? 8'(LINE_WORDS - 1) : 8'd0;
  assign w_ar_size = (r_type == CACHE_LINE_REQ) ? 3'd3 : r_size;

  assign w_beat_idx     = r_beat_cnt[CNT_W-2:0];
  assign w_len_mismatch = (32'(r_beat_cnt) != 32'(w_ar_len));
  assign w_beat_err     = axi_resp_i.r.resp[1]
                        | (axi_resp_i.r.id != r_id)
                        | r_beat_cnt[CNT_W-1]
                        | (axi_resp_i.r.last & w_len_mismatch);

  // Write-channel handshakes are never used by a read-only master.
  assign w_unused = ^{axi_resp_i.aw_ready, axi_resp_i.w_ready,
                      axi_resp_i.b_valid, axi_resp_i.b};

`ifdef SY_AXI_RD_TIMEOUT_EN
  logic [31:0] r_wdog_cnt;
  logic        w_wdog_run;

  assign w_wdog_run = ((r_state == S_AR) && !w_ar_hs) || ((r_state == S_RDATA) && !w_r_hs);
  assign w_timeout  = w_wdog_run && (r_wdog_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !w_wdog_run) begin
      r_wdog_cnt <= '0;
    end else begin
      r_wdog_cnt <= r_wdog_cnt + 32'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: defaults come first so no path through the case leaves a signal unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) w_state_nxt = S_AR;
      end
      S_AR: begin
        if (w_ar_hs)        w_state_nxt = S_RDATA;
        else if (w_timeout) w_state_nxt = S_RESP;
      end
      S_RDATA: begin
        if (w_r_hs && axi_resp_i.r.last) w_state_nxt = S_RESP;
        else if (w_timeout)              w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_rsp_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.b_ready  = 1'b1;
    axi_req_o.ar_valid = (r_state == S_AR);
    axi_req_o.ar.id    = r_id;
    axi_req_o.ar.addr  = w_ar_addr;
    axi_req_o.ar.len   = w_ar_len;
    axi_req_o.ar.size  = w_ar_size;
    axi_req_o.ar.burst = 2'b01;
    axi_req_o.ar.cache = 4'b0010;
    axi_req_o.r_ready  = (r_state == S_RDATA);
  end

  assign bus.req_ready_o = (r_state == S_IDLE);
  assign bus.rsp_valid_o = (r_state == S_RESP);
  assign bus.rsp_err_o   = (r_state == S_RESP) && r_err;
  assign bus.rsp_data_o  = r_buf;

  // NOTE: the line buffer is reset too, so data from an abandoned burst never leaks out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_type     <= SINGLE_REQ;
      r_addr     <= '0;
      r_size     <= '0;
      r_id       <= '0;
      r_buf      <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_type     <= ad_req_t'(bus.req_type_i);
      r_addr     <= bus.req_addr_i;
      r_size     <= bus.req_size_i;
      r_id       <= bus.req_id_i;
      r_buf      <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_r_hs) begin
      if (!r_beat_cnt[CNT_W-1]) begin
        r_buf[w_beat_idx] <= axi_resp_i.r.data;
        r_beat_cnt        <= r_beat_cnt + CNT_W'(1);
      end
      r_err <= r_err | w_beat_err;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sy_axi_rd_adapter.sv
// Directed bench for sy_axi_rd_adapter: expected AR fields and responses are queued
// when a request is issued and compared when the adapter presents them.
module tb_sy_axi_rd_adapter;
  import sy_axi::*;

  localparam int LW = 4;
  localparam int DW = 64 * LW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } exp_rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sy_axi_rd_adapter_if #(.LINE_WORDS(LW)) bus ();
  req_t  axi_req;
  resp_t axi_resp;

  sy_axi_rd_adapter #(.LINE_WORDS(LW), .TIMEOUT_CYCLES(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .axi_req_o  (axi_req),
    .axi_resp_i (axi_resp)
  );

  ax_chan_t ar_q[$];
  exp_rsp_t rsp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ax_chan_t mk_ar(input logic [63:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [3:0] id);
    ax_chan_t a;
    a       = '0;
    a.id    = id;
    a.addr  = addr;
    a.len   = len;
    a.size  = size;
    a.burst = 2'b01;
    a.cache = 4'b0010;
    return a;
  endfunction

  function automatic exp_rsp_t mk_rsp(input logic [DW-1:0] data, input logic err);
    exp_rsp_t r;
    r.data = data;
    r.err  = err;
    return r;
  endfunction

  // Accept a request; ends on the negedge where the adapter sits in AR.
  task automatic issue(input logic typ, input logic [63:0] addr, input logic [2:0] size,
                       input logic [3:0] id);
    @(negedge clk);
    check("req_ready_idle", DW'(bus.req_ready_o), DW'(1'b1));
    bus.req_valid_i = 1'b1;
    bus.req_type_i  = typ;
    bus.req_addr_i  = addr;
    bus.req_size_i  = size;
    bus.req_id_i    = id;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.req_id_i    = 4'hF;
    bus.req_size_i  = 3'd7;
    check("ar_valid_next_cycle", DW'(axi_req.ar_valid), DW'(1'b1));
  endtask

  task automatic do_ar(input int stall);
    ax_chan_t e;
    e = ar_q.pop_front();
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      check("ar_valid", DW'(axi_req.ar_valid), DW'(1'b1));
      check("ar_fields", DW'(axi_req.ar), DW'(e));
      check("req_ready_in_ar", DW'(bus.req_ready_o), DW'(1'b0));
      if (i == stall) axi_resp.ar_ready = 1'b1;
    end
    @(negedge clk);
    axi_resp.ar_ready = 1'b0;
    check("ar_valid_after_hs", DW'(axi_req.ar_valid), DW'(1'b0));
  endtask

  task automatic beat(input logic [63:0] data, input logic [1:0] resp, input logic [3:0] id,
                      input logic last);
    int t;
    t = 0;
    while (!axi_req.r_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("r_ready", DW'(axi_req.r_ready), DW'(1'b1));
    axi_resp.r_valid   = 1'b1;
    axi_resp.r.data    = data;
    axi_resp.r.resp    = resp;
    axi_resp.r.id      = id;
    axi_resp.r.last    = last;
    @(negedge clk);
    axi_resp.r_valid   = 1'b0;
    axi_resp.r         = '0;
  endtask

  // Called on the negedge right after the last beat: RESP must already be visible.
  task automatic do_resp(input int hold);
    exp_rsp_t e;
    e = rsp_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      check("rsp_valid", DW'(bus.rsp_valid_o), DW'(1'b1));
      check("rsp_data", bus.rsp_data_o, e.data);
      check("rsp_err", DW'(bus.rsp_err_o), DW'(e.err));
      check("req_ready_in_resp", DW'(bus.req_ready_o), DW'(1'b0));
      if (i == hold) bus.rsp_ready_i = 1'b1;
    end
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("rsp_valid_after_hs", DW'(bus.rsp_valid_o), DW'(1'b0));
    check("req_ready_back_idle", DW'(bus.req_ready_o), DW'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_type_i  = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_size_i  = '0;
    bus.req_id_i    = '0;
    bus.rsp_ready_i = 1'b0;
    axi_resp        = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", DW'(bus.req_ready_o), DW'(1'b1));
    check("rst_rsp_valid", DW'(bus.rsp_valid_o), DW'(1'b0));
    check("rst_rsp_err", DW'(bus.rsp_err_o), DW'(1'b0));
    check("rst_rsp_data", bus.rsp_data_o, '0);
    check("rst_ar_valid", DW'(axi_req.ar_valid), DW'(1'b0));
    check("rst_r_ready", DW'(axi_req.r_ready), DW'(1'b0));
    check("tie_aw_valid", DW'(axi_req.aw_valid), DW'(1'b0));
    check("tie_w_valid", DW'(axi_req.w_valid), DW'(1'b0));
    check("tie_b_ready", DW'(axi_req.b_ready), DW'(1'b1));
    check("tie_aw_w_payload", DW'({axi_req.aw, axi_req.w}), '0);
    rst = 1'b0;

    // Line request, unaligned address, zero-wait slave
    ar_q.push_back(mk_ar(64'h8000_1020, 8'd3, 3'd3, 4'd3));
    rsp_q.push_back(mk_rsp({64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b0));
    issue(1'b1, 64'h8000_1038, 3'd1, 4'd3);
    do_ar(0);
    for (int k = 0; k < 4; k++) beat(64'hA0 + 64'(k), 2'b00, 4'd3, k == 3);
    do_resp(0);

    // Single request: address and size pass through, data in word 0
    ar_q.push_back(mk_ar(64'h1000_0004, 8'd0, 3'd2, 4'd5));
    rsp_q.push_back(mk_rsp(DW'(64'h1234), 1'b0));
    issue(1'b0, 64'h1000_0004, 3'd2, 4'd5);
    do_ar(0);
    beat(64'h1234, 2'b00, 4'd5, 1'b1);
    do_resp(0);

    // SLVERR on beat 2: all words still stored, error flagged
    ar_q.push_back(mk_ar(64'h0000_2000, 8'd3, 3'd3, 4'd1));
    rsp_q.push_back(mk_rsp({64'hB3, 64'hB2, 64'hB1, 64'hB0}, 1'b1));
    issue(1'b1, 64'h0000_2010, 3'd0, 4'd1);
    do_ar(0);
    for (int k = 0; k < 4; k++) beat(64'hB0 + 64'(k), (k == 2) ? 2'b10 : 2'b00, 4'd1, k == 3);
    do_resp(0);

    // Early last after 2 beats
    ar_q.push_back(mk_ar(64'h0000_0040, 8'd3, 3'd3, 4'd2));
    rsp_q.push_back(mk_rsp({64'h0, 64'h0, 64'hC1, 64'hC0}, 1'b1));
    issue(1'b1, 64'h0000_0040, 3'd3, 4'd2);
    do_ar(0);
    beat(64'hC0, 2'b00, 4'd2, 1'b0);
    beat(64'hC1, 2'b00, 4'd2, 1'b1);
    do_resp(0);

    // Late last: fifth beat discarded, error flagged
    ar_q.push_back(mk_ar(64'h0000_0100, 8'd3, 3'd3, 4'd1));
    rsp_q.push_back(mk_rsp({64'hF3, 64'hF2, 64'hF1, 64'hF0}, 1'b1));
    issue(1'b1, 64'h0000_0118, 3'd3, 4'd1);
    do_ar(0);
    for (int k = 0; k < 5; k++) beat(64'hF0 + 64'(k), 2'b00, 4'd1, k == 4);
    do_resp(0);

    // Wrong R id
    ar_q.push_back(mk_ar(64'h3000_0008, 8'd0, 3'd3, 4'd4));
    rsp_q.push_back(mk_rsp(DW'(64'h55), 1'b1));
    issue(1'b0, 64'h3000_0008, 3'd3, 4'd4);
    do_ar(0);
    beat(64'h55, 2'b00, 4'd9, 1'b1);
    do_resp(0);

    // Back-pressure: ar_ready low 5 cycles, rsp_ready low 3 cycles
    ar_q.push_back(mk_ar(64'h8000_0000, 8'd3, 3'd3, 4'd7));
    rsp_q.push_back(mk_rsp({64'hD3, 64'hD2, 64'hD1, 64'hD0}, 1'b0));
    issue(1'b1, 64'h8000_0008, 3'd2, 4'd7);
    do_ar(5);
    for (int k = 0; k < 4; k++) beat(64'hD0 + 64'(k), 2'b00, 4'd7, k == 3);
    do_resp(3);

    // Reset in RDATA after 2 beats abandons the transaction
    ar_q.push_back(mk_ar(64'h5000_0000, 8'd3, 3'd3, 4'd6));
    issue(1'b1, 64'h5000_0000, 3'd3, 4'd6);
    do_ar(0);
    beat(64'hE0, 2'b00, 4'd6, 1'b0);
    beat(64'hE1, 2'b00, 4'd6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", DW'(bus.req_ready_o), DW'(1'b1));
    check("midrst_rsp_valid", DW'(bus.rsp_valid_o), DW'(1'b0));
    check("midrst_r_ready", DW'(axi_req.r_ready), DW'(1'b0));
    check("midrst_rsp_data", bus.rsp_data_o, '0);
    rst = 1'b0;

    // Normal operation resumes after reset
    ar_q.push_back(mk_ar(64'h0000_0010, 8'd0, 3'd3, 4'd0));
    rsp_q.push_back(mk_rsp(DW'(64'hFEED), 1'b0));
    issue(1'b0, 64'h0000_0010, 3'd3, 4'd0);
    do_ar(0);
    beat(64'hFEED, 2'b00, 4'd0, 1'b1);
    do_resp(0);

`ifdef SY_AXI_RD_TIMEOUT_EN
    // Watchdog: ar_ready never asserted, response 16 cycles after AR entry
    begin
      int cyc;
      issue(1'b1, 64'h0000_0200, 3'd3, 4'd2);
      cyc = 0;
      while (!bus.rsp_valid_o && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("timeout_cycles", DW'(cyc), DW'(16));
      check("timeout_err", DW'(bus.rsp_err_o), DW'(1'b1));
      check("timeout_data", bus.rsp_data_o, '0);
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      check("timeout_back_idle", DW'(bus.req_ready_o), DW'(1'b1));
    end
`endif

    check("sb_ar_drained", DW'(ar_q.size()), DW'(0));
    check("sb_rsp_drained", DW'(rsp_q.size()), DW'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
